// File: rtl/ram_master_pkg.sv
// Shared types and default widths for the DPRAM bus initiator.
package ram_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_DRAIN
  } state_e;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

endpackage

// File: rtl/ram_beat_ctr.sv
// Loadable burst address / beat counter; address wraps modulo 2^ADDR_W.
module ram_beat_ctr #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  import ram_master_pkg::*;

  logic [LEN_W-1:0] rem;

  // The final beat does not advance, so the address holds through a read drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= load_addr;
      rem  <= load_len;
    end else if (step && !last) begin
      addr <= addr + ADDR_W'(1);
      rem  <= rem - LEN_W'(1);
    end
  end

  assign last = (rem == '0);

endmodule

// File: rtl/ram_master.sv
// Single-port DPRAM bus initiator: burst requests in, cs/wren/oen/addr out, owns the data bus.
module ram_master #(
  parameter int ADDR_W = ram_master_pkg::ADDR_W,
  parameter int DATA_W = ram_master_pkg::DATA_W,
  parameter int LEN_W  = ram_master_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_cs,
  output logic              mem_wren,
  output logic              mem_oen
);
  import ram_master_pkg::*;

  // vld_pipe[0]: bus carries read data this cycle; vld_pipe[STAGES]: rdata valid.
  localparam int STAGES = 1;

  state_e              state;
  logic                accept;
  logic                wr_beat;
  logic                rd_cyc;
  logic                last;
  logic [STAGES:0]     vld_pipe;

  assign accept  = req_valid && req_ready;
  assign wr_beat = (state == WR) && wdata_valid;
  assign rd_cyc  = (state == RD);

  ram_beat_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_addr (req_addr),
    .load_len  (req_len),
    .step      (wr_beat || rd_cyc),
    .addr      (mem_addr),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_cs      <= 1'b0;
      mem_oen     <= 1'b0;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          state       <= req_write ? WR : RD;
          mem_cs      <= 1'b1;
          mem_oen     <= !req_write;
          req_ready   <= 1'b0;
          wdata_ready <= req_write;
        end
        WR: if (wdata_valid && last) begin
          state       <= IDLE;
          mem_cs      <= 1'b0;
          wdata_ready <= 1'b0;
          req_ready   <= 1'b1;
          done        <= 1'b1;
        end
        RD: if (last) state <= RD_DRAIN;
        RD_DRAIN: begin
          state     <= IDLE;
          mem_cs    <= 1'b0;
          mem_oen   <= 1'b0;
          req_ready <= 1'b1;
          done      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM returns data one cycle after each address cycle; register it one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rdata    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_cyc};
      if (vld_pipe[0]) rdata <= mem_data;
    end
  end

  assign rdata_valid = vld_pipe[STAGES];
  assign mem_wren    = wr_beat;
  assign mem_data    = (mem_cs && mem_wren) ? wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_master.sv
// Randomized bench for ram_master against a transaction-level memory model.
module tb_ram_master;

  logic       clk;
  logic       rst_n;
  logic       req_valid, req_write;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wdata_valid;
  logic [7:0] wdata;
  logic       req_ready, wdata_ready, rdata_valid, done;
  logic [7:0] rdata, mem_addr;
  logic       mem_cs, mem_wren, mem_oen;
  wire  [7:0] mem_data;

  ram_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_wren(mem_wren), .mem_oen(mem_oen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Naive RAM port: write on cs&&wren, registered read driven while cs&&oen.
  bit [7:0] ram [256];
  bit [7:0] rd_q;
  int       wr_strobes = 0;
  always @(posedge clk) begin
    if (mem_cs && mem_wren) begin
      ram[mem_addr] <= mem_data;
      wr_strobes    <= wr_strobes + 1;
    end else if (mem_cs && mem_oen) begin
      rd_q <= ram[mem_addr];
    end
  end
  assign mem_data = (mem_cs && mem_oen && !mem_wren) ? rd_q : 8'hzz;

  // Reference: memory image after each completed beat, plus expected write count.
  bit [7:0] ref_mem [256];
  bit [7:0] wbuf [16];
  int       exp_writes = 0;
  int       n_cmp = 0;
  int       n_bad = 0;
  bit       poking = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] addr_of(input logic [7:0] a, input int k);
    return 8'((int'(a) + k) % 256);
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
    if (poking) begin
      req_valid = 1'b0;
      poking    = 1'b0;
    end
  endtask

  task automatic accept(input bit w, input logic [7:0] a, input logic [3:0] l);
    int t = 0;
    req_write = w; req_addr = a; req_len = l; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_cs", mem_cs, 0);
      chk("idle_wren", mem_wren, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_rvalid", rdata_valid, 0);
      next_cycle();
    end
  endtask

  task automatic wr_cycle(input logic [7:0] a, input int k, input bit v);
    wdata_valid = v;
    wdata       = v ? wbuf[k] : 8'($urandom);
    @(negedge clk);
    chk("wr_cs", mem_cs, 1);
    chk("wr_oen", mem_oen, 0);
    chk("wr_wren", mem_wren, v);
    chk("wr_addr", mem_addr, addr_of(a, k));
    chk("wr_wready", wdata_ready, 1);
    chk("wr_rready", req_ready, 0);
    chk("wr_done", done, 0);
    if (v) chk("wr_bus", mem_data, wbuf[k]);
    next_cycle();
  endtask

  // mode 0: no stalls, 1: 3-cycle stalls before beats 2 and 3, 2: random stalls.
  task automatic wr_body(input logic [7:0] a, input int n, input int mode, input bit poke);
    int st;
    if (poke) begin
      req_write = 1'b0; req_addr = ~a; req_len = 4'd3; req_valid = 1'b1;
      poking = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      st = (mode == 1 && (k == 1 || k == 2)) ? 3 :
           (mode == 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      for (int s = 0; s < st; s++) wr_cycle(a, k, 1'b0);
      wr_cycle(a, k, 1'b1);
      ref_mem[addr_of(a, k)] = wbuf[k];
      exp_writes++;
    end
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("wr_end_done", done, 1);
    chk("wr_end_cs", mem_cs, 0);
    chk("wr_end_wren", mem_wren, 0);
    chk("wr_end_ready", req_ready, 1);
    chk("wr_end_wready", wdata_ready, 0);
    next_cycle();
  endtask

  task automatic rd_body(input logic [7:0] a, input int n, input int stop);
    for (int c = 1; c <= n + 2 && c <= stop; c++) begin
      @(negedge clk);
      chk("rd_cs", mem_cs, c <= n + 1);
      chk("rd_oen", mem_oen, c <= n + 1);
      chk("rd_wren", mem_wren, 0);
      if (c <= n) chk("rd_addr", mem_addr, addr_of(a, c - 1));
      else if (c == n + 1) chk("rd_drain_addr", mem_addr, addr_of(a, n - 1));
      chk("rd_valid", rdata_valid, c >= 3);
      if (c >= 3) chk("rd_data", rdata, ref_mem[addr_of(a, c - 3)]);
      chk("rd_done", done, c == n + 2);
      chk("rd_ready", req_ready, c == n + 2);
      chk("rd_wready", wdata_ready, 0);
      next_cycle();
    end
  endtask

  initial begin
    logic [7:0] a;
    int         l;
    bit         w;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_cs", mem_cs, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_oen", mem_oen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wready", wdata_ready, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // single write then back-to-back read
    wbuf[0] = 8'h5A;
    accept(1'b1, 8'h10, 4'd0);
    req_write = 1'b0; req_addr = 8'h10; req_len = 4'd0; req_valid = 1'b1;
    wr_body(8'h10, 1, 0, 1'b0);
    req_valid = 1'b0;
    rd_body(8'h10, 1, 99);

    // 16-beat wrapping write and read-back
    for (int i = 0; i < 16; i++) wbuf[i] = 8'(i);
    accept(1'b1, 8'hF8, 4'd15);
    wr_body(8'hF8, 16, 0, 1'b0);
    accept(1'b0, 8'hF8, 4'd15);
    rd_body(8'hF8, 16, 99);

    // write with stalls on beats 2 and 3
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    accept(1'b1, 8'h40, 4'd3);
    wr_body(8'h40, 4, 1, 1'b0);
    accept(1'b0, 8'h40, 4'd3);
    rd_body(8'h40, 4, 99);

    // read held back-to-back with a write
    for (int i = 0; i < 2; i++) wbuf[i] = 8'($urandom);
    accept(1'b0, 8'h40, 4'd1);
    req_write = 1'b1; req_addr = 8'h80; req_len = 4'd1; req_valid = 1'b1;
    rd_body(8'h40, 2, 99);
    req_valid = 1'b0;
    wr_body(8'h80, 2, 0, 1'b0);

    // request pulsed while busy writing
    for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
    accept(1'b1, 8'h90, 4'd2);
    wr_body(8'h90, 3, 0, 1'b1);
    idle(1);

    // randomized bursts
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      l = $urandom_range(0, 15);
      if (w) begin
        for (int j = 0; j <= l; j++) wbuf[j] = 8'($urandom);
        accept(1'b1, a, 4'(l));
        wr_body(a, l + 1, 2, 1'($urandom_range(0, 1)));
      end else begin
        accept(1'b0, a, 4'(l));
        rd_body(a, l + 1, 99);
      end
      idle($urandom_range(0, 2));
    end

    // reset in cycle 3 of an 8-beat read
    accept(1'b0, 8'hF8, 4'd7);
    rd_body(8'hF8, 8, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_rdata", rdata, 0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk("mid_rst_cs", mem_cs, 0);
      chk("mid_rst_oen", mem_oen, 0);
      chk("mid_rst_wren", mem_wren, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_rvalid", rdata_valid, 0);
      chk("mid_rst_ready", req_ready, 1);
    end

    for (int i = 0; i < 256; i++) chk("ram_image", ram[i], ref_mem[i]);
    chk("write_count", wr_strobes, exp_writes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
